// File: rtl/xfer_pkg.sv
// xfer_pkg: shared types and default parameters for the transfer controller.
//   xfer_state_t : controller FSM states (IDLE, ENQ, ACK, DEQ)
//   DEF_DEPTH    : default queue capacity in words
//   DEF_LEN_W    : default width of the queue length input
//   DEF_TIMEOUT  : default watchdog limit in cycles
package xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENQ  = 2'd1,
    ACK  = 2'd2,
    DEQ  = 2'd3
  } xfer_state_t;

  localparam int DEF_DEPTH   = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/xfer_watchdog.sv
// xfer_watchdog: loadable cycle counter with an expire flag.
// Only instantiated when XFER_TIMEOUT_EN is defined.
//   clock   : counter clock (rising edge)
//   reset   : asynchronous active-low reset
//   load    : synchronous clear of the count (has priority over run)
//   run     : count one cycle
//   expired : count has reached MAX; the counter holds there
module xfer_watchdog
  import xfer_pkg::*;
#(
  parameter int MAX = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CW'(MAX));

endmodule

// File: rtl/xfer_ctrl.sv
// xfer_ctrl: sequences word transfers from the deserializer into the queue
// and drains the queue on request.
//
// Optional feature: define XFER_TIMEOUT_EN to add a watchdog that abandons an
// ENQ/DEQ after TIMEOUT cycles without the expected length change and sets
// the sticky err_out. Without it the FSM waits indefinitely and err_out is 0.
//
// Ports:
//   clock         : controller clock (rising edge), at least 2x queue clock
//   reset         : asynchronous active-low reset
//   des_ready_in  : deserializer word-ready level
//   des_ack_out   : four-phase ack to the deserializer (registered)
//   q_len_in      : current queue occupancy
//   q_enqueue_out : enqueue strobe to the queue (registered)
//   q_dequeue_out : dequeue strobe to the queue (registered)
//   deq_req_in    : dequeue request, single-cycle pulse
//   full_out      : q_len_in == DEPTH (combinational)
//   empty_out     : q_len_in == 0 (combinational)
//   err_out       : sticky timeout error (registered)
//   state_dbg     : current FSM state, for observation only
//
// Handshake semantics:
//   Deserializer (four-phase): ready rises -> ack rises once the word is in
//   the queue -> ready falls -> ack falls -> next word may start. If ready
//   falls while the word is still being enqueued, the word is still committed
//   and ack pulses for exactly one cycle.
//   Queue (strobe-until-confirmed): a strobe is held high until q_len_in has
//   moved by one from the value snapshotted when the transfer started, and
//   drops on the following edge, so a slower queue clock sees it once.
module xfer_ctrl
  import xfer_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             des_ready_in,
  output logic             des_ack_out,
  input  logic [LEN_W-1:0] q_len_in,
  output logic             q_enqueue_out,
  output logic             q_dequeue_out,
  input  logic             deq_req_in,
  output logic             full_out,
  output logic             empty_out,
  output logic             err_out,
  output logic [1:0]       state_dbg
);

  xfer_state_t      state, state_d;
  logic             enq_q, enq_d;
  logic             ack_q, ack_d;
  logic             deq_q, deq_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d;
  logic [LEN_W-1:0] snap_q, snap_d;

  logic             full, empty;
  logic [LEN_W-1:0] snap_inc, snap_dec;
  logic             expired;

  assign full  = (q_len_in == LEN_W'(DEPTH));
  assign empty = (q_len_in == '0);

  // Full/empty guards keep these away from the wrap cases.
  assign snap_inc = snap_q + LEN_W'(1);
  assign snap_dec = snap_q - LEN_W'(1);

`ifdef XFER_TIMEOUT_EN
  logic wd_load, wd_run;

  // Count only while waiting for the queue; cleared everywhere else so each
  // transfer starts from zero.
  assign wd_run  = (state == ENQ) || (state == DEQ);
  assign wd_load = !wd_run;

  xfer_watchdog #(
    .MAX(TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .load   (wd_load),
    .run    (wd_run),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      enq_q  <= 1'b0;
      ack_q  <= 1'b0;
      deq_q  <= 1'b0;
      err_q  <= 1'b0;
      pend_q <= 1'b0;
      snap_q <= '0;
    end else begin
      state  <= state_d;
      enq_q  <= enq_d;
      ack_q  <= ack_d;
      deq_q  <= deq_d;
      err_q  <= err_d;
      pend_q <= pend_d;
      snap_q <= snap_d;
    end
  end

  always_comb begin
    state_d = state;
    enq_d   = enq_q;
    ack_d   = ack_q;
    deq_d   = deq_q;
    err_d   = err_q;
    pend_d  = pend_q;
    snap_d  = snap_q;

    case (state)
      IDLE: begin
        enq_d = 1'b0;
        ack_d = 1'b0;
        deq_d = 1'b0;
        // A waiting word wins unless the queue is full or no word is ready;
        // a pending dequeue is then served as soon as the word is acked.
        if (pend_q && !empty && (full || !des_ready_in)) begin
          state_d = DEQ;
          snap_d  = q_len_in;
          pend_d  = 1'b0;
        end else if (des_ready_in && !full) begin
          state_d = ENQ;
          snap_d  = q_len_in;
        end
        // Nothing to take out: the request is discarded.
        if (pend_q && empty) begin
          pend_d = 1'b0;
        end
      end

      ENQ: begin
        // A length change on the last watchdog cycle still counts as a commit.
        if (q_len_in == snap_inc) begin
          enq_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK;
        end else if (expired) begin
          enq_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          enq_d = 1'b1;
        end
      end

      ACK: begin
        if (!des_ready_in) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end else begin
          ack_d = 1'b1;
        end
      end

      DEQ: begin
        if (q_len_in == snap_dec) begin
          deq_d   = 1'b0;
          state_d = IDLE;
        end else if (expired) begin
          deq_d   = 1'b0;
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = IDLE;
        end else begin
          deq_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A new request is never lost to a same-cycle clear.
    if (deq_req_in) begin
      pend_d = 1'b1;
    end
  end

  assign des_ack_out   = ack_q;
  assign q_enqueue_out = enq_q;
  assign q_dequeue_out = deq_q;
  assign err_out       = err_q;
  assign full_out      = full;
  assign empty_out     = empty;
  assign state_dbg     = state;

endmodule

// File: tb/tb_xfer_ctrl.sv
// tb_xfer_ctrl: self-checking bench for xfer_ctrl. The bench plays the queue
// (length moves by one a chosen number of cycles after a strobe is first
// seen) and the deserializer (four-phase ready/ack), and checks strobe
// lengths, ordering, ack behaviour and flags against what the controller
// rules require.
module tb_xfer_ctrl;
  import xfer_pkg::*;

  localparam int DEPTH   = 8;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic             des_ready_in;
  logic             des_ack_out;
  logic [LEN_W-1:0] q_len_in;
  logic             q_enqueue_out;
  logic             q_dequeue_out;
  logic             deq_req_in;
  logic             full_out;
  logic             empty_out;
  logic             err_out;
  logic [1:0]       state_dbg;

  int q_len;
  assign q_len_in = q_len[LEN_W-1:0];

  xfer_ctrl #(
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .des_ready_in (des_ready_in),
    .des_ack_out  (des_ack_out),
    .q_len_in     (q_len_in),
    .q_enqueue_out(q_enqueue_out),
    .q_dequeue_out(q_dequeue_out),
    .deq_req_in   (deq_req_in),
    .full_out     (full_out),
    .empty_out    (empty_out),
    .err_out      (err_out),
    .state_dbg    (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- environment model state ----------------
  bit freeze;
  int delay_max;
  int enq_delay, deq_delay, enq_wait, deq_wait, enq_run, deq_run;
  bit enq_done, deq_done, ack_prev;
  int enq_eps, deq_eps, ack_eps, enq_commits, deq_commits;
  int enq_full, deq_empty, both_hi, cyc;
  int first_enq_cyc, first_deq_cyc;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  task automatic env_clear();
    cyc = 0; enq_eps = 0; deq_eps = 0; ack_eps = 0;
    enq_commits = 0; deq_commits = 0; enq_full = 0; deq_empty = 0; both_hi = 0;
    enq_wait = 0; deq_wait = 0; enq_run = 0; deq_run = 0;
    enq_done = 0; deq_done = 0; ack_prev = des_ack_out; freeze = 0;
    first_enq_cyc = -1; first_deq_cyc = -1;
    exp_q.delete(); obs_q.delete();
  endtask

  // One controller cycle: sample #1 after the edge, then let the queue model
  // react. Expected strobe length (delay+1) goes to exp_q at commit time, the
  // observed length to obs_q when the strobe falls.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (q_enqueue_out && q_dequeue_out) both_hi++;
    if (des_ack_out && !ack_prev) ack_eps++;
    ack_prev = des_ack_out;

    if (q_enqueue_out) begin
      if (enq_run == 0) begin
        enq_eps++;
        if (first_enq_cyc < 0) first_enq_cyc = cyc;
      end
      enq_run++;
      if (!enq_done && !freeze) begin
        if (enq_wait >= enq_delay) begin
          if (q_len >= DEPTH) enq_full++; else q_len++;
          enq_done = 1; enq_commits++;
          exp_q.push_back(8'(enq_delay + 1));
        end else enq_wait++;
      end
    end else if (enq_run != 0) begin
      obs_q.push_back(8'(enq_run));
      enq_run = 0; enq_wait = 0; enq_done = 0;
      enq_delay = $urandom_range(delay_max, 0);
    end

    if (q_dequeue_out) begin
      if (deq_run == 0) begin
        deq_eps++;
        if (first_deq_cyc < 0) first_deq_cyc = cyc;
      end
      deq_run++;
      if (!deq_done && !freeze) begin
        if (deq_wait >= deq_delay) begin
          if (q_len <= 0) deq_empty++; else q_len--;
          deq_done = 1; deq_commits++;
          exp_q.push_back(8'(deq_delay + 1));
        end else deq_wait++;
      end
    end else if (deq_run != 0) begin
      obs_q.push_back(8'(deq_run));
      deq_run = 0; deq_wait = 0; deq_done = 0;
      deq_delay = $urandom_range(delay_max, 0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; des_ready_in = 1'b0; deq_req_in = 1'b0; q_len = 0;
    delay_max = 0; enq_delay = 50; deq_delay = 0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({q_enqueue_out, q_dequeue_out, des_ack_out, err_out} !== 4'b0000) begin
      bad++; $display("FAIL reset_outputs: got %b want 0000",
                      {q_enqueue_out, q_dequeue_out, des_ack_out, err_out});
    end
    total++;
    if (state_dbg !== IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE);
    end
    total++;
    if (empty_out !== 1'b1 || full_out !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got empty=%b full=%b want 1 0", empty_out, full_out);
    end
    reset = 1'b1;
    env_clear();
    enq_delay = 50;
    des_ready_in = 1'b1;
    for (int i = 0; i < 20 && !q_enqueue_out; i++) step();
    total++;
    if (q_enqueue_out !== 1'b1) begin
      bad++; $display("FAIL reset_pre_enq: got %b want 1", q_enqueue_out);
    end
    // Assert reset between edges: outputs must clear without a clock.
    #2 reset = 1'b0;
    #1;
    total++;
    if ({q_enqueue_out, q_dequeue_out, des_ack_out, err_out} !== 4'b0000) begin
      bad++; $display("FAIL reset_async: got %b want 0000",
                      {q_enqueue_out, q_dequeue_out, des_ack_out, err_out});
    end
    des_ready_in = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    total++;
    if (state_dbg !== IDLE || q_enqueue_out !== 1'b0) begin
      bad++; $display("FAIL reset_release: got state=%0d enq=%b want 0 0", state_dbg, q_enqueue_out);
    end
    total++;
    if (q_len !== 0) begin
      bad++; $display("FAIL reset_len: got %0d want 0", q_len);
    end
    env_clear();
  endtask

  task automatic test_enqueue(input int start_len, input int d, input int hold);
    int ack_bad;
    env_clear();
    q_len = start_len; delay_max = d; enq_delay = d;
    des_ready_in = 1'b1;
    for (int i = 0; i < 100 && !des_ack_out; i++) step();
    total++;
    if (first_enq_cyc != 2) begin
      bad++; $display("FAIL enq_latency: got %0d want 2", first_enq_cyc);
    end
    total++;
    if (des_ack_out !== 1'b1 || q_enqueue_out !== 1'b0) begin
      bad++; $display("FAIL enq_ack_rise: got ack=%b enq=%b want 1 0", des_ack_out, q_enqueue_out);
    end
    total++;
    if (q_len != start_len + 1) begin
      bad++; $display("FAIL enq_len: got %0d want %0d", q_len, start_len + 1);
    end
    ack_bad = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (des_ack_out !== 1'b1 || q_enqueue_out !== 1'b0) ack_bad++;
    end
    total++;
    if (ack_bad != 0) begin
      bad++; $display("FAIL enq_ack_hold: got %0d bad cycles want 0", ack_bad);
    end
    des_ready_in = 1'b0;
    step();
    total++;
    if (des_ack_out !== 1'b0 || state_dbg !== IDLE) begin
      bad++; $display("FAIL enq_ack_fall: got ack=%b state=%0d want 0 0", des_ack_out, state_dbg);
    end
    step();
    total++;
    if (exp_q.size() != 1 || obs_q.size() != 1) begin
      bad++; $display("FAIL enq_sb_count: got exp=%0d obs=%0d want 1 1", exp_q.size(), obs_q.size());
    end else begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) begin
        bad++; $display("FAIL enq_strobe_len: got %0d want %0d", o, e);
      end
    end
  endtask

  task automatic test_full();
    int err_cnt;
    env_clear();
    q_len = DEPTH; delay_max = 3; enq_delay = 2; deq_delay = 1;
    des_ready_in = 1'b1;
    err_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (q_enqueue_out || q_dequeue_out || des_ack_out || !full_out) err_cnt++;
    end
    total++;
    if (err_cnt != 0) begin
      bad++; $display("FAIL full_backpressure: got %0d bad cycles want 0", err_cnt);
    end
    deq_req_in = 1'b1;
    step();
    deq_req_in = 1'b0;
    for (int i = 0; i < 100 && !des_ack_out; i++) step();
    total++;
    if (deq_eps != 1 || enq_eps != 1 || deq_commits != 1 || enq_commits != 1) begin
      bad++; $display("FAIL full_counts: got deq=%0d enq=%0d want 1 1", deq_eps, enq_eps);
    end
    total++;
    if (!(first_deq_cyc > 0 && first_deq_cyc < first_enq_cyc)) begin
      bad++; $display("FAIL full_order: got deq@%0d enq@%0d want deq first", first_deq_cyc, first_enq_cyc);
    end
    total++;
    if (q_len != DEPTH || des_ack_out !== 1'b1) begin
      bad++; $display("FAIL full_refill: got len=%0d ack=%b want %0d 1", q_len, des_ack_out, DEPTH);
    end
    des_ready_in = 1'b0;
    step(); step();
  endtask

  task automatic test_simultaneous();
    env_clear();
    q_len = 3; delay_max = 5; enq_delay = $urandom_range(5, 0); deq_delay = $urandom_range(5, 0);
    des_ready_in = 1'b1; deq_req_in = 1'b1;
    step();
    deq_req_in = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (des_ack_out) des_ready_in = 1'b0;
      step();
    end
    total++;
    if (!(first_enq_cyc > 0 && first_deq_cyc > first_enq_cyc)) begin
      bad++; $display("FAIL simul_order: got enq@%0d deq@%0d want enq first", first_enq_cyc, first_deq_cyc);
    end
    total++;
    if (enq_eps != 1 || deq_eps != 1 || ack_eps != 1) begin
      bad++; $display("FAIL simul_counts: got enq=%0d deq=%0d ack=%0d want 1 1 1", enq_eps, deq_eps, ack_eps);
    end
    total++;
    if (q_len != 3 || state_dbg !== IDLE) begin
      bad++; $display("FAIL simul_final: got len=%0d state=%0d want 3 0", q_len, state_dbg);
    end
  endtask

  task automatic test_empty_drop();
    env_clear();
    q_len = 0; delay_max = 0; deq_delay = 0; des_ready_in = 1'b0;
    deq_req_in = 1'b1;
    step();
    deq_req_in = 1'b0;
    for (int i = 0; i < 20; i++) step();
    total++;
    if (deq_eps != 0 || empty_out !== 1'b1) begin
      bad++; $display("FAIL empty_drop: got deq=%0d empty=%b want 0 1", deq_eps, empty_out);
    end
    // If the request had survived it would fire now that a word is present.
    q_len = 1;
    for (int i = 0; i < 20; i++) step();
    total++;
    if (deq_eps != 0 || empty_out !== 1'b0 || q_len != 1) begin
      bad++; $display("FAIL empty_flag_clear: got deq=%0d empty=%b len=%0d want 0 0 1",
                      deq_eps, empty_out, q_len);
    end
    q_len = 0;
    step();
  endtask

  task automatic test_random();
    int drop_wait, reqs, sb_bad;
    bit raise_ok;
    env_clear();
    q_len = $urandom_range(4, 0); delay_max = 6;
    enq_delay = $urandom_range(6, 0); deq_delay = $urandom_range(6, 0);
    des_ready_in = 1'b0; deq_req_in = 1'b0;
    reqs = 0; drop_wait = 0;
    for (int i = 0; i < 800; i++) begin
      raise_ok = (i < 700);
      if (des_ready_in && des_ack_out) begin
        if (drop_wait == 0) des_ready_in = 1'b0; else drop_wait--;
      end else if (!des_ready_in && !des_ack_out && raise_ok && $urandom_range(3, 0) == 0) begin
        des_ready_in = 1'b1;
        drop_wait = $urandom_range(3, 0);
      end
      if (!deq_req_in && raise_ok && $urandom_range(11, 0) == 0) begin
        deq_req_in = 1'b1; reqs++;
      end else deq_req_in = 1'b0;
      step();
    end
    total++;
    if (both_hi != 0 || enq_full != 0 || deq_empty != 0) begin
      bad++; $display("FAIL rand_safety: got both=%0d enq_full=%0d deq_empty=%0d want 0 0 0",
                      both_hi, enq_full, deq_empty);
    end
    total++;
    if (ack_eps != enq_eps || enq_commits != enq_eps || enq_eps == 0) begin
      bad++; $display("FAIL rand_ack: got ack=%0d enq=%0d commits=%0d want equal nonzero",
                      ack_eps, enq_eps, enq_commits);
    end
    total++;
    if (deq_eps > reqs || deq_commits != deq_eps || deq_eps == 0) begin
      bad++; $display("FAIL rand_deq: got deq=%0d commits=%0d reqs=%0d", deq_eps, deq_commits, reqs);
    end
    total++;
    if (exp_q.size() != obs_q.size()) begin
      bad++; $display("FAIL rand_sb_count: got obs=%0d want %0d", obs_q.size(), exp_q.size());
    end
    sb_bad = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) sb_bad++;
    end
    total++;
    if (sb_bad != 0) begin
      bad++; $display("FAIL rand_strobe_len: got %0d wrong lengths want 0", sb_bad);
    end
    total++;
    if (err_out !== 1'b0 || state_dbg !== IDLE) begin
      bad++; $display("FAIL rand_end: got err=%b state=%0d want 0 0", err_out, state_dbg);
    end
  endtask

`ifdef XFER_TIMEOUT_EN
  task automatic test_timeout();
    int hi, err_cnt;
    env_clear();
    q_len = 2; freeze = 1; delay_max = 0;
    des_ready_in = 1'b1;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (q_enqueue_out) hi++;
      else if (hi > 0) break;
    end
    des_ready_in = 1'b0;
    total++;
    if (hi != TIMEOUT) begin
      bad++; $display("FAIL timeout_len: got %0d want %0d", hi, TIMEOUT);
    end
    err_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (err_out !== 1'b1 || des_ack_out !== 1'b0) err_cnt++;
    end
    total++;
    if (err_cnt != 0 || ack_eps != 0) begin
      bad++; $display("FAIL timeout_sticky: got %0d bad cycles ack=%0d want 0 0", err_cnt, ack_eps);
    end
    total++;
    if (state_dbg !== IDLE || q_len != 2) begin
      bad++; $display("FAIL timeout_idle: got state=%0d len=%0d want 0 2", state_dbg, q_len);
    end
    reset = 1'b0;
    #1;
    total++;
    if (err_out !== 1'b0) begin
      bad++; $display("FAIL timeout_reset: got %b want 0", err_out);
    end
    reset = 1'b1;
    freeze = 0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_enqueue(0, 10, 3);
    for (int k = 0; k < 4; k++) begin
      test_enqueue($urandom_range(DEPTH - 2, 0), $urandom_range(12, 0), $urandom_range(6, 0));
    end
    test_full();
    test_simultaneous();
    test_empty_drop();
    test_random();
`ifdef XFER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
